univ_shift_reg: RTL

Parametrised universal register: a WIDTH-bit bank of asynchronously cleared flops that adds hold, shift-right, shift-left and parallel-load modes, plus a framed burst engine. The burst engine shifts exactly WIDTH bits under a start/busy/done handshake. It is the general-purpose storage/serialiser building block for datapath and serial-link front ends, and it replaces fixed-width parallel-in/parallel-out registers.

---
 rtl/univ_shift_reg_if.sv | 30 +++
 rtl/univ_shift_reg.sv | 121 ++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_if.sv
// Signal bundle for univ_shift_reg: manual-mode controls, burst handshake and
// register/serial outputs. The master drives controls; the register is the slave.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] par_in;
    logic             ser_in_r;
    logic             ser_in_l;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             ser_out_r;
    logic             ser_out_l;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output en, mode, par_in, ser_in_r, ser_in_l, start,
        input  q, ser_out_r, ser_out_l, busy, done, bit_cnt
    );

    modport slave (
        input  en, mode, par_in, ser_in_r, ser_in_l, start,
        output q, ser_out_r, ser_out_l, busy, done, bit_cnt
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register (hold / shift right / shift left / load) with a
// framed burst engine that shifts exactly WIDTH bits under start/busy/done.
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    univ_shift_reg_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic             dir_left_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] bit_cnt_r;

    logic [WIDTH-1:0] shr_s;
    logic [WIDTH-1:0] shl_s;
    logic [WIDTH-1:0] burst_s;
    logic             burst_req_s;

    // Shift candidates and burst request decode
    always_comb begin
        shr_s       = {bus.ser_in_r, q_r[WIDTH-1:1]};
        shl_s       = {q_r[WIDTH-2:0], bus.ser_in_l};
        burst_req_s = bus.start && ((bus.mode == MODE_SHR) || (bus.mode == MODE_SHL));
        if (dir_left_r) begin
            burst_s = shl_s;
        end else begin
            burst_s = shr_s;
        end
    end

    // Control FSM and datapath; start only triggers a burst for shift modes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            q_r        <= {WIDTH{1'b0}};
            dir_left_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bit_cnt_r  <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r    <= 1'b0;
                    bit_cnt_r <= CNT_ZERO;
                    if (burst_req_s) begin
                        dir_left_r <= (bus.mode == MODE_SHL);
                        busy_r     <= 1'b1;
                        state_r    <= ST_SHIFT;
                    end else if (bus.en) begin
                        case (bus.mode)
                            MODE_HOLD: q_r <= q_r;
                            MODE_SHR:  q_r <= shr_s;
                            MODE_SHL:  q_r <= shl_s;
                            MODE_LOAD: q_r <= bus.par_in;
                            default:   q_r <= q_r;
                        endcase
                    end else begin
                        q_r <= q_r;
                    end
                end
                ST_SHIFT: begin
                    // en low stalls both the data and the shift count
                    if (bus.en) begin
                        q_r       <= burst_s;
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        if (bit_cnt_r == CNT_LAST) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end else begin
                        q_r <= q_r;
                    end
                end
                ST_DONE: begin
                    done_r    <= 1'b0;
                    bit_cnt_r <= CNT_ZERO;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    bit_cnt_r <= CNT_ZERO;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.q         = q_r;
    assign bus.ser_out_r = q_r[0];
    assign bus.ser_out_l = q_r[WIDTH-1];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.bit_cnt   = bit_cnt_r;

    logic unused_full_s;
    assign unused_full_s = (bit_cnt_r == CNT_FULL);
endmodule
